// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: FSM states, empty-candidate sentinel, key map.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRESSED  = 2'd1,
    ST_RELEASED = 2'd2
  } state_t;

  // Candidates are {none, code}; any real key has bit 4 clear.
  localparam logic [4:0] KEY_NONE = 5'h10;

  // Nibble (row*4 + col) holds the hex legend of that key.
  localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    return KEY_MAP[{r, c, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Per-scan candidate capture and saturating count of identical consecutive scans.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4,
  parameter int SW             = $clog2(DEBOUNCE_SCANS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sample,
  input  logic          eos,
  input  logic [4:0]    sample_cand,
  output logic [4:0]    scan_cand,
  output logic [SW-1:0] stable_next
);

  logic [4:0]    cur_cand;
  logic [4:0]    prev_cand;
  logic [SW-1:0] stable_q;

  // The last column is sampled on the EOS cycle itself, so fold it in combinationally.
  always_comb begin
    scan_cand = cur_cand;
    if (sample && (cur_cand == KEY_NONE))
      scan_cand = sample_cand;
    if (scan_cand != prev_cand)
      stable_next = SW'(1);
    else if (stable_q == SW'(DEBOUNCE_SCANS))
      stable_next = stable_q;
    else
      stable_next = stable_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_cand  <= KEY_NONE;
      prev_cand <= KEY_NONE;
      stable_q  <= '0;
    end else if (eos) begin
      cur_cand  <= KEY_NONE;
      prev_cand <= scan_cand;
      stable_q  <= stable_next;
    end else if (sample) begin
      cur_cand  <= scan_cand;
    end
  end

endmodule

// File: rtl/keypad_scan_entry.sv
// 4x4 keypad scanner: column strobe, row sync, debounce, press/release FSM and
// a 4-digit shift-in entry register.
module keypad_scan_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_BITS      = 17,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row,
  input  logic        clear,
  output logic [3:0]  col,
  output logic [15:0] value,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held
);

  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);

  logic [SCAN_BITS+1:0] counter;
  logic [1:0]           sel;
  logic [3:0]           row_s1;
  logic [3:0]           row_s2;
  logic                 sample;
  logic                 eos;
  logic [4:0]           sample_cand;
  logic [4:0]           scan_cand;
  logic [SW-1:0]        stable_next;
  logic                 accept;
  state_t               state;

  assign sel    = counter[SCAN_BITS+1:SCAN_BITS];
  assign col    = ~(4'b0001 << sel);
  assign sample = &counter[SCAN_BITS-1:0];
  assign eos    = &counter;

  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= '0;
      row_s1  <= 4'hF;
      row_s2  <= 4'hF;
    end else begin
      counter <= counter + 1'b1;
      row_s1  <= row;
      row_s2  <= row_s1;
    end
  end

  // Lowest pressed row of the active column wins.
  always_comb begin
    sample_cand = KEY_NONE;
    for (int r = 3; r >= 0; r--)
      if (!row_s2[r])
        sample_cand = {1'b0, key_map(2'(r), sel)};
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
    .SW             (SW)
  ) u_debounce (
    .clk         (clk),
    .reset       (reset),
    .sample      (sample),
    .eos         (eos),
    .sample_cand (sample_cand),
    .scan_cand   (scan_cand),
    .stable_next (stable_next)
  );

  assign accept = eos && (state == ST_IDLE) && (scan_cand != KEY_NONE) &&
                  (stable_next == SW'(DEBOUNCE_SCANS));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      value     <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (eos) begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              state     <= ST_PRESSED;
              key_code  <= scan_cand[3:0];
              key_valid <= 1'b1;
              key_held  <= 1'b1;
            end
          end
          ST_PRESSED: begin
            if ((scan_cand == KEY_NONE) && (stable_next == SW'(DEBOUNCE_SCANS))) begin
              state    <= ST_RELEASED;
              key_held <= 1'b0;
            end
          end
          ST_RELEASED: state <= ST_IDLE;
          default:     state <= ST_IDLE;
        endcase
      end
      if (clear)
        value <= accept ? {12'h000, scan_cand[3:0]} : 16'h0000;
      else if (accept)
        value <= {value[11:0], scan_cand[3:0]};
    end
  end

endmodule

// File: tb/tb_keypad_scan_entry.sv
// Bench for keypad_scan_entry with SCAN_BITS=2, DEBOUNCE_SCANS=2 (16 clocks per scan).
module tb_keypad_scan_entry;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row;
  logic        clear = 1'b0;
  logic [3:0]  col;
  logic [15:0] value;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys = 16'h0000;   // bit r*4+c = key at row r, column c pressed

  keypad_scan_entry #(.SCAN_BITS(2), .DEBOUNCE_SCANS(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .clear     (clear),
    .col       (col),
    .value     (value),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Passive keypad matrix: a pressed key shorts its row to its strobed column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col[c] && keys[r*4+c]) row[r] = 1'b0;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  always @(negedge clk) if (key_valid) pulses++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scan-level reference model.
  int          keymap[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};
  int          m_prev, m_stable, m_state, m_pulses;
  logic        m_valid, m_held;
  logic [3:0]  m_code;
  logic [15:0] m_value;

  task automatic model_reset();
    m_prev = 16; m_stable = 0; m_state = 0;
    m_valid = 0; m_held = 0; m_code = 0; m_value = 0;
  endtask

  function automatic int first_key(input logic [15:0] k);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (k[r*4+c]) return r*4 + c;
    return 16;
  endfunction

  task automatic model_step(input logic [15:0] k, input bit clr);
    int cand;
    cand = first_key(k);
    if (cand == m_prev) m_stable = (m_stable < D) ? m_stable + 1 : D;
    else                m_stable = 1;
    m_prev  = cand;
    m_valid = 0;
    if (clr) m_value = 0;
    case (m_state)
      0: if (cand != 16 && m_stable == D) begin
           m_state = 1; m_code = 4'(keymap[cand]); m_valid = 1; m_held = 1;
           m_value = {m_value[11:0], m_code}; m_pulses++;
         end
      1: if (cand == 16 && m_stable == D) begin m_state = 2; m_held = 0; end
      default: m_state = 0;
    endcase
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, " key_valid"}, 32'(key_valid), 32'(m_valid));
    chk({tag, " key_code"},  32'(key_code),  32'(m_code));
    chk({tag, " value"},     32'(value),     32'(m_value));
    chk({tag, " key_held"},  32'(key_held),  32'(m_held));
  endtask

  // Entered and left at the negedge of the counter==0 cycle.
  task automatic scan(input logic [15:0] k, input int clr_at, input string tag);
    keys = k;
    for (int i = 0; i < 16; i++) begin
      clear = (i == clr_at);
      @(negedge clk);
    end
    clear = 1'b0;
    model_step(k, clr_at >= 0);
    check_outputs(tag);
  endtask

  task automatic press_release(input logic [15:0] k, input string tag);
    repeat (3) scan(k, -1, tag);
    repeat (3) scan(16'h0, -1, tag);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " col"},       32'(col),       32'h0000_000E);
    chk({tag, " value"},     32'(value),     32'h0);
    chk({tag, " key_code"},  32'(key_code),  32'h0);
    chk({tag, " key_valid"}, 32'(key_valid), 32'h0);
    chk({tag, " key_held"},  32'(key_held),  32'h0);
  endtask

  typedef struct { int r; int c; logic [3:0] code; } key_vec_t;
  key_vec_t    key_tbl[16];
  logic [3:0]  col_tbl[16];

  initial begin
    int p0;
    logic [15:0] k;
    key_tbl = '{'{0,0,4'h1}, '{0,1,4'h2}, '{0,2,4'h3}, '{0,3,4'hA},
                '{1,0,4'h4}, '{1,1,4'h5}, '{1,2,4'h6}, '{1,3,4'hB},
                '{2,0,4'h7}, '{2,1,4'h8}, '{2,2,4'h9}, '{2,3,4'hC},
                '{3,0,4'h0}, '{3,1,4'hF}, '{3,2,4'hE}, '{3,3,4'hD}};
    for (int i = 0; i < 16; i++) col_tbl[i] = ~(4'b0001 << (i / 4));
    m_pulses = 0;
    model_reset();

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;

    // 1: idle scan, column rotation
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t1 col[%0d]", i), 32'(col), 32'(col_tbl[i]));
      @(negedge clk);
    end
    model_step(16'h0, 0);
    check_outputs("t1");

    // 2: hold '6' for 5 scans
    p0 = pulses;
    repeat (5) scan(16'h0040, -1, "t2 press");
    chk("t2 key_code", 32'(key_code), 32'h6);
    chk("t2 value", 32'(value), 32'h0006);
    chk("t2 pulses", 32'(pulses - p0), 32'd1);
    scan(16'h0, -1, "t2 rel1");
    chk("t2 held rel1", 32'(key_held), 32'd1);
    scan(16'h0, -1, "t2 rel2");
    chk("t2 held rel2", 32'(key_held), 32'd0);
    scan(16'h0, -1, "t2 rel3");

    // 3: 1,2,3,A,5
    p0 = pulses;
    press_release(16'h0001, "t3 1");
    press_release(16'h0002, "t3 2");
    press_release(16'h0004, "t3 3");
    press_release(16'h0008, "t3 A");
    press_release(16'h0020, "t3 5");
    chk("t3 value", 32'(value), 32'h23A5);
    chk("t3 pulses", 32'(pulses - p0), 32'd5);

    // key map table
    for (int i = 0; i < 16; i++) begin
      k = 16'h0;
      k[key_tbl[i].r*4 + key_tbl[i].c] = 1'b1;
      repeat (3) scan(k, -1, "map press");
      chk($sformatf("map code r%0d c%0d", key_tbl[i].r, key_tbl[i].c),
          32'(key_code), 32'(key_tbl[i].code));
      repeat (3) scan(16'h0, -1, "map rel");
    end
    chk("map value", 32'(value), 32'h0FED);

    // 4: bounce on '1' then hold
    p0 = pulses;
    keys = 16'h0;
    for (int i = 0; i < 48; i++) begin
      if (i % 3 == 0) keys[0] = ~keys[0];
      @(negedge clk);
    end
    chk("t4 bounce pulses", 32'(pulses - p0), 32'd0);
    model_step(16'h0001, 0);
    model_step(16'h0, 0);
    model_step(16'h0, 0);
    check_outputs("t4 bounce");
    scan(16'h0001, -1, "t4 hold1");
    chk("t4 valid hold1", 32'(key_valid), 32'd0);
    scan(16'h0001, -1, "t4 hold2");
    chk("t4 valid hold2", 32'(key_valid), 32'd1);
    chk("t4 code", 32'(key_code), 32'h1);
    scan(16'h0001, -1, "t4 hold3");
    repeat (3) scan(16'h0, -1, "t4 rel");
    chk("t4 pulses", 32'(pulses - p0), 32'd1);

    // 5: '4' and '9' together, then release only '4'
    p0 = pulses;
    repeat (3) scan(16'h0410, -1, "t5 both");
    chk("t5 code", 32'(key_code), 32'h4);
    repeat (4) scan(16'h0400, -1, "t5 nine");
    chk("t5 pulses", 32'(pulses - p0), 32'd1);
    repeat (3) scan(16'h0, -1, "t5 rel");

    // random key groups
    for (int g = 0; g < 40; g++) begin
      int kind, hold, clr_at;
      kind = int'($urandom_range(0, 3));
      case (kind)
        0:       k = 16'h0;
        3:       k = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
        default: k = 16'h1 << $urandom_range(0, 15);
      endcase
      hold = int'($urandom_range(1, 4));
      for (int s = 0; s < hold; s++) begin
        clr_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : -1;
        scan(k, clr_at, $sformatf("rand g%0d s%0d", g, s));
      end
    end
    repeat (3) scan(16'h0, -1, "rand rel");

    // 6: clear, 1234, clear coinciding with 'E'
    scan(16'h0, 7, "t6 clr");
    chk("t6 cleared", 32'(value), 32'h0);
    press_release(16'h0001, "t6 1");
    press_release(16'h0002, "t6 2");
    press_release(16'h0004, "t6 3");
    press_release(16'h0010, "t6 4");
    chk("t6 value 1234", 32'(value), 32'h1234);
    scan(16'h4000, -1, "t6 E1");
    scan(16'h4000, 15, "t6 E2");
    chk("t6 value E", 32'(value), 32'h000E);
    chk("t6 valid E", 32'(key_valid), 32'd1);

    // reset mid-scan while the key is still held
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("t6 midreset");
    reset = 1'b0;
    model_reset();
    repeat (3) scan(16'h4000, -1, "t6 after");
    chk("t6 after value", 32'(value), 32'h000E);
    repeat (3) scan(16'h0, -1, "t6 rel");

    chk("total pulses", 32'(pulses), 32'(m_pulses));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
